req_capture_dispatch: RTL
=========================

// Module: req_capture_dispatch
// PURPOSE
//  Input stage ahead of the 8-line priority encode path. Passes asynchronous request lines through
//  synchronisers, latches them into sticky pending bits and picks the highest-index unmasked pending bit.
//  Presents the pick as a registered index with a valid/ready handshake; the pending bit clears on accept.
// PARAMETERS
//  N_REQ        8   number of request lines; power of two, >=2
//  IDX_W        3   index width, $clog2(N_REQ); derived, not overridden
//  SYNC_STAGES  2   synchroniser depth per request line, >=2
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   N_REQ  raw request lines, asynchronous to clk
//  mask       in   N_REQ  1 = line excluded from selection; its pending bit is kept
//  out_valid  out  1      out_idx holds a granted request
//  out_ready  in   1      consumer accepts when out_valid && out_ready at a rising edge
//  out_idx    out  IDX_W  index of the granted line
//  pending    out  N_REQ  current pending register, masked bits included
//  lost       out  1      1-cycle pulse: new event on a line whose bit is already pending
// BEHAVIOUR
//  Reset (async, rst_n low): sync flops, pending, out_idx = 0; out_valid = 0; lost = 0; FSM = IDLE.
//   Reset mid-handshake drops out_valid at once and discards all pending state.
//  Sync: req[i] -> SYNC_STAGES flops -> req_s[i]. Event: see CONFIGURATION.
//  pending[i] next = (pending[i] & ~clr[i]) | evt[i]. Set wins when set and clear hit the same bit in one cycle.
//  lost = |(evt & pending & ~clr), registered.
//  Selection: cand = pending & ~mask; pick = highest set index (N_REQ-1 highest priority).
//  FSM:
//   IDLE:    cand != 0 -> out_idx <= pick, out_valid <= 1, go PRESENT. cand == 0 -> stay.
//   PRESENT: out_idx/out_valid held stable regardless of new requests or mask changes.
//            out_ready = 1 -> clr[out_idx] = 1, out_valid <= 0, go IDLE.
//  Throughput: at most one grant per 2 cycles (one IDLE cycle between grants).
//  out_idx holds the last grant while out_valid = 0.
//  Latency: req high sampled at edge E0 -> out_valid high after edge E0+SYNC_STAGES+1 (4th edge, default).
//  Empty: out_valid stays 0 and pending = 0. All lines masked: pending accumulates, out_valid stays 0.
//  Full: every bit pending -> further events on those lines raise lost only.
// CONFIGURATION
//  Macro REQ_EDGE_EN.
//   Defined:   evt = req_s & ~req_s_d (rising-edge detect; 1 extra flop per line).
//              A held-high line produces one event. lost is active.
//   Undefined: evt = req_s (level). A held-high line re-sets its bit in the cycle after accept.
//              lost is tied to 0. Latency is identical in both modes.
// STRUCTURE
//  Shared package prio_pkg: N_REQ_DEF = 8, SYNC_STAGES_DEF = 2, typedef enum {IDLE, PRESENT} disp_state_t.
//  Sub-module prio_pick: combinational N_REQ -> IDX_W highest-set-index finder with any_o flag.
//  Also reused by the downstream encode stage.
//  Synchronisers, pending register and FSM live in this module.
// TESTING
//  1. rst_n low mid-PRESENT -> out_valid, pending, lost = 0 asynchronously, without waiting for a clk edge.
//     After release, no grant unless req is re-asserted.
//  2. req = 8'b0000_0100 pulse, out_ready = 1 -> out_valid on 4th edge, out_idx = 2.
//     pending returns to 0 after accept.
//  3. req = 8'b1000_0001 together, out_ready = 1 -> grants out_idx = 7 then 0, two cycles apart.
//     pending = 8'h00 afterwards.
//  4. mask = 8'h80, req = 8'h81 -> grant idx 0 only, pending = 8'h80.
//     Then mask = 8'h00 -> grant idx 7.
//  5. out_ready = 0 while idx 3 presented, then req[6] rises -> out_idx stays 3 until accepted.
//     idx 6 is granted next.
//  6. REQ_EDGE_EN: second rising edge on req[5] while pending[5] = 1 -> lost pulses once.
//     Undefined: req[5] held high -> re-granted every 2 cycles, lost = 0.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared definitions for the request capture / priority encode path.
package prio_pkg;

  localparam int N_REQ_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } disp_state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational highest-set-index finder; any_o flags a non-zero input.
module prio_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any_o
);

  // Ascending scan so the last (highest) set bit is the one that sticks.
  always_comb begin
    idx   = '0;
    any_o = |vec;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/req_capture_dispatch.sv
// Synchronises raw requests, holds them as sticky pending bits and dispatches the highest unmasked one.
// Build option: define REQ_EDGE_EN for rising-edge events (and lost reporting) instead of level events.
module req_capture_dispatch
  import prio_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEF,
  parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [N_REQ-1:0]  pending,
  output logic              lost,
  output disp_state_t       state
);

  // Handshake: out_idx is transferred on a rising edge where out_valid && out_ready;
  // while out_valid is high, out_idx and out_valid stay stable until that edge.

  logic [N_REQ-1:0] sync_q [SYNC_STAGES];
  logic [N_REQ-1:0] req_s;
  logic [N_REQ-1:0] evt;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] pick;
  logic             pick_any;
  logic             lost_next;
  disp_state_t      state_next;
  logic             valid_next;
  logic [IDX_W-1:0] idx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= req;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

`ifdef REQ_EDGE_EN
  logic [N_REQ-1:0] req_s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_s_d <= '0;
    else        req_s_d <= req_s;
  end

  assign evt       = req_s & ~req_s_d;
  assign lost_next = |(evt & pending & ~clr);
`else
  assign evt       = req_s;
  assign lost_next = 1'b0;
`endif

  // Only the presented line is cleared, and only on the accepting edge.
  always_comb begin
    clr = '0;
    if (state == PRESENT && out_ready) clr[out_idx] = 1'b1;
  end

  // Set wins over clear so an event landing on the accept edge is not dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      lost    <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | evt;
      lost    <= lost_next;
    end
  end

  assign cand = pending & ~mask;

  prio_pick #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_pick (
    .vec   (cand),
    .idx   (pick),
    .any_o (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      state     <= state_next;
      out_valid <= valid_next;
      out_idx   <= idx_next;
    end
  end

  // out_idx keeps the last grant after accept; it only moves when a new grant is made.
  always_comb begin
    state_next = state;
    valid_next = out_valid;
    idx_next   = out_idx;
    case (state)
      IDLE: begin
        if (pick_any) begin
          idx_next   = pick;
          valid_next = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule
